// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmit controller: FSM state codes,
// line levels and a frame-length helper. Optional parity: SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   // Clock cycles from first start-bit cycle to last stop-bit cycle.
   function automatic int unsigned frame_len(
      input int unsigned dw,
      input int unsigned cpb,
      input bit          par_en
   );
      return (dw + (par_en ? 32'd3 : 32'd2)) * cpb;
   endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run=1, clears when run=0.
// Ports: clk, reset (async high), run; tc = count at its last value.
module baud_tick_counter #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tc
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!run || tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // With CLKS_PER_BIT=1 the counter never leaves 0, so tc is constant 1.
   assign tc = (r_cnt == LAST);

endmodule

// File: rtl/serial_tx_controller.sv
// Byte-to-serial frame transmitter: start, data LSB first, [parity], stop.
// Ports: clk, reset (async high); tx_data/tx_valid/tx_ready producer
// handshake, gen_odd_par parity select; tx_serial line (idles high),
// tx_busy (frame in progress), tx_done (last stop-bit cycle).
// Optional parity slot enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_controller
   import serial_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic                  gen_odd_par,
   output logic                  tx_serial,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_nxt;
   logic [BW-1:0]         r_bit;
   logic [BW-1:0]         w_bit_nxt;
   logic                  r_serial;
   logic                  r_ready;
   logic                  w_line_nxt;
   logic                  w_run;
   logic                  w_tc;
   logic                  w_hs;

`ifdef SERIAL_TX_PARITY_EN
   logic                  r_par;
   logic                  w_par_nxt;
`else
   logic                  w_unused_par;
   assign w_unused_par = gen_odd_par;
`endif

   assign w_run = (r_state != S_IDLE);
   assign w_hs  = tx_valid & r_ready;

   baud_tick_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .reset(reset),
      .run  (w_run),
      .tc   (w_tc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
`ifdef SERIAL_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               w_state_nxt = S_START;
               w_shift_nxt = tx_data;
`ifdef SERIAL_TX_PARITY_EN
               w_par_nxt   = (^tx_data) ^ gen_odd_par;
`endif
            end
         end
         S_START: begin
            if (w_tc) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_tc) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit == BIT_LAST) begin
                  w_bit_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (w_tc) w_state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_tc) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The line is registered from the next state so each bit appears in the
   // same cycle its state becomes current.
   always_comb begin
      w_line_nxt = LINE_IDLE;
      case (w_state_nxt)
         S_START:  w_line_nxt = LINE_START;
         S_DATA:   w_line_nxt = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: w_line_nxt = w_par_nxt;
`endif
         default:  w_line_nxt = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_bit    <= '0;
         r_serial <= LINE_IDLE;
         r_ready  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         r_par    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_bit    <= w_bit_nxt;
         r_serial <= w_line_nxt;
         r_ready  <= (w_state_nxt == S_IDLE);
`ifdef SERIAL_TX_PARITY_EN
         r_par    <= w_par_nxt;
`endif
      end
   end

   assign tx_ready  = r_ready;
   assign tx_serial = r_serial;
   assign tx_busy   = w_run;
   assign tx_done   = (r_state == S_STOP) & w_tc;

endmodule

// File: tb/tb_serial_tx_controller.sv
// Scoreboard bench for serial_tx_controller at CLKS_PER_BIT=4 and =1.
// Expected frames are queued at each handshake and popped after capture.
module tb_serial_tx_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d0, d1;
   logic       v0, v1, o0, o1;
   logic       rdy0, ser0, busy0, done0;
   logic       rdy1, ser1, busy1, done1;

   always #5 clk = ~clk;

   serial_tx_controller #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .reset(rst), .tx_data(d0), .tx_valid(v0),
      .tx_ready(rdy0), .gen_odd_par(o0), .tx_serial(ser0),
      .tx_busy(busy0), .tx_done(done0)
   );

   serial_tx_controller #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .reset(rst), .tx_data(d1), .tx_valid(v1),
      .tx_ready(rdy1), .gen_odd_par(o1), .tx_serial(ser1),
      .tx_busy(busy1), .tx_done(done1)
   );

   typedef struct {
      logic [11:0] bits;
      int          n;
   } frame_t;

   frame_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic cap_line [1:64];
   int   cap_done, cap_busy, cap_rdy;
   logic cap_end_ser, cap_end_busy, cap_end_rdy, cap_end_done;

   function automatic frame_t mk_frame(input logic [7:0] d, input logic odd);
      frame_t f;
      int ones;
      ones = $countones(d);
      f.bits = '1;
      f.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
`ifdef SERIAL_TX_PARITY_EN
      // even total ones when odd=0, odd total when odd=1
      f.bits[9]  = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      f.bits[10] = 1'b1;
      f.n = 11;
`else
      f.bits[9] = 1'b1;
      f.n = 10;
`endif
      return f;
   endfunction

   function automatic int line_errs(input frame_t f, input int cpb);
      int e;
      e = 0;
      for (int c = 1; c <= f.n * cpb; c++)
         if (cap_line[c] !== f.bits[(c-1)/cpb]) e++;
      return e;
   endfunction

   task automatic send(input bit sel, input logic [7:0] d, input logic odd);
      @(negedge clk);
      if (sel) begin v1 = 1'b1; d1 = d; o1 = odd; end
      else begin v0 = 1'b1; d0 = d; o0 = odd; end
      @(posedge clk);
      sb.push_back(mk_frame(d, odd));
   endtask

   task automatic capture(input bit sel, input int len, input bit hold,
                          input logic [7:0] nd, input logic nodd,
                          input int pulse_at);
      logic s, b, r, dn;
      cap_done = 0; cap_busy = 0; cap_rdy = 0;
      for (int c = 1; c <= len + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            if (sel) begin v1 = hold; d1 = nd; o1 = nodd; end
            else begin v0 = hold; d0 = nd; o0 = nodd; end
         end
         if (pulse_at > 0 && c == pulse_at) begin
            if (sel) v1 = 1'b1; else v0 = 1'b1;
         end
         if (pulse_at > 0 && c == pulse_at + 1) begin
            if (sel) v1 = 1'b0; else v0 = 1'b0;
         end
         s  = sel ? ser1  : ser0;
         b  = sel ? busy1 : busy0;
         r  = sel ? rdy1  : rdy0;
         dn = sel ? done1 : done0;
         if (c <= len) begin
            cap_line[c] = s;
            if (dn === 1'b1 && cap_done == 0) cap_done = c;
            if (b === 1'b1) cap_busy++;
            if (r === 1'b1) cap_rdy++;
         end else begin
            cap_end_ser = s; cap_end_busy = b;
            cap_end_rdy = r; cap_end_done = dn;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ser0, rdy0, busy0, done0} !== 4'b1100) begin
         n_bad++;
         $display("FAIL reset_dut4: got %b want 1100",
                  {ser0, rdy0, busy0, done0});
      end
      n_cmp++;
      if ({ser1, rdy1, busy1, done1} !== 4'b1100) begin
         n_bad++;
         $display("FAIL reset_dut1: got %b want 1100",
                  {ser1, rdy1, busy1, done1});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero_even;
      frame_t f;
      int len;
      send(0, 8'h00, 1'b0);
      len = sb[$].n * 4;
      capture(0, len, 0, 8'h00, 1'b0, 0);
      f = sb.pop_front();
      n_cmp++;
      if (line_errs(f, 4) !== 0) begin
         n_bad++;
         $display("FAIL zero_even_line: got %0d bad cycles want 0",
                  line_errs(f, 4));
      end
      n_cmp++;
      if (cap_done !== len) begin
         n_bad++;
         $display("FAIL zero_even_done: got cycle %0d want %0d", cap_done, len);
      end
      n_cmp++;
      if (cap_busy !== len || cap_rdy !== 0) begin
         n_bad++;
         $display("FAIL zero_even_busy: got busy %0d rdy %0d want %0d 0",
                  cap_busy, cap_rdy, len);
      end
      n_cmp++;
      if ({cap_end_ser, cap_end_busy, cap_end_rdy, cap_end_done} !== 4'b1010) begin
         n_bad++;
         $display("FAIL zero_even_end: got %b want 1010",
                  {cap_end_ser, cap_end_busy, cap_end_rdy, cap_end_done});
      end
   endtask

   task automatic test_parity;
      frame_t f;
      int len;
      send(0, 8'h00, 1'b1);
      len = sb[$].n * 4;
      capture(0, len, 0, 8'h00, 1'b0, 0);
      f = sb.pop_front();
      n_cmp++;
      if (line_errs(f, 4) !== 0 || cap_done !== len) begin
         n_bad++;
         $display("FAIL par_odd_frame: got %0d bad cycles done %0d want 0 %0d",
                  line_errs(f, 4), cap_done, len);
      end
`ifdef SERIAL_TX_PARITY_EN
      n_cmp++;
      if (cap_line[37] !== 1'b1) begin
         n_bad++;
         $display("FAIL par_odd_bit: got %b want 1", cap_line[37]);
      end
`endif
      send(0, 8'h01, 1'b0);
      len = sb[$].n * 4;
      capture(0, len, 0, 8'h00, 1'b0, 0);
      f = sb.pop_front();
      n_cmp++;
      if (line_errs(f, 4) !== 0 || cap_done !== len) begin
         n_bad++;
         $display("FAIL par_01_frame: got %0d bad cycles done %0d want 0 %0d",
                  line_errs(f, 4), cap_done, len);
      end
      n_cmp++;
      if (cap_line[5] !== 1'b1 || cap_line[9] !== 1'b0) begin
         n_bad++;
         $display("FAIL par_01_lsb: got d0 %b d1 %b want 1 0",
                  cap_line[5], cap_line[9]);
      end
`ifdef SERIAL_TX_PARITY_EN
      n_cmp++;
      if (cap_line[37] !== 1'b1) begin
         n_bad++;
         $display("FAIL par_01_bit: got %b want 1", cap_line[37]);
      end
`endif
   endtask

   task automatic test_pattern_81;
      frame_t f;
      int len;
      send(0, 8'h81, 1'b0);
      len = sb[$].n * 4;
      capture(0, len, 0, 8'h00, 1'b0, 0);
      f = sb.pop_front();
      n_cmp++;
      if (line_errs(f, 4) !== 0 || cap_done !== len) begin
         n_bad++;
         $display("FAIL p81_frame: got %0d bad cycles done %0d want 0 %0d",
                  line_errs(f, 4), cap_done, len);
      end
`ifndef SERIAL_TX_PARITY_EN
      n_cmp++;
      if (len != 40 || cap_line[33] !== 1'b1 || cap_end_ser !== 1'b1) begin
         n_bad++;
         $display("FAIL p81_noparity: got len %0d d7 %b want 40 1",
                  len, cap_line[33]);
      end
`endif
   endtask

   task automatic test_back_to_back;
      frame_t f;
      int len;
      send(0, 8'hA5, 1'b0);
      len = sb[$].n * 4;
      capture(0, len, 1, 8'h3C, 1'b0, 0);
      f = sb.pop_front();
      n_cmp++;
      if (line_errs(f, 4) !== 0 || cap_done !== len) begin
         n_bad++;
         $display("FAIL b2b_first: got %0d bad cycles done %0d want 0 %0d",
                  line_errs(f, 4), cap_done, len);
      end
      n_cmp++;
      if (cap_rdy !== 0 || cap_end_rdy !== 1'b1 || cap_end_ser !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_gap: got rdy %0d idle_rdy %b line %b want 0 1 1",
                  cap_rdy, cap_end_rdy, cap_end_ser);
      end
      @(posedge clk);
      sb.push_back(mk_frame(8'h3C, 1'b0));
      len = sb[$].n * 4;
      capture(0, len, 0, 8'h00, 1'b0, 0);
      f = sb.pop_front();
      n_cmp++;
      if (cap_line[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_start: got %b want 0", cap_line[1]);
      end
      n_cmp++;
      if (line_errs(f, 4) !== 0 || cap_done !== len || cap_rdy !== 0) begin
         n_bad++;
         $display("FAIL b2b_second: got %0d bad done %0d rdy %0d want 0 %0d 0",
                  line_errs(f, 4), cap_done, cap_rdy, len);
      end
`ifdef SERIAL_TX_PARITY_EN
      n_cmp++;
      if (cap_line[37] !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_par: got %b want 0", cap_line[37]);
      end
`endif
   endtask

   task automatic test_fast;
      frame_t f;
      int len;
      int extra;
      send(1, 8'hFF, 1'b1);
      len = sb[$].n;
      capture(1, len, 0, 8'hFF, 1'b1, 5);
      f = sb.pop_front();
      n_cmp++;
      if (line_errs(f, 1) !== 0 || cap_done !== len) begin
         n_bad++;
         $display("FAIL fast_frame: got %0d bad cycles done %0d want 0 %0d",
                  line_errs(f, 1), cap_done, len);
      end
`ifdef SERIAL_TX_PARITY_EN
      n_cmp++;
      if (len != 11 || cap_line[10] !== 1'b1) begin
         n_bad++;
         $display("FAIL fast_par: got len %0d par %b want 11 1",
                  len, cap_line[10]);
      end
`endif
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (busy1 !== 1'b0) extra++;
      end
      n_cmp++;
      if (extra !== 0 || cap_end_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL fast_ignore: got %0d busy cycles want 0", extra);
      end
   endtask

   task automatic test_reset_mid_frame;
      frame_t f;
      int dn;
      send(0, 8'hA5, 1'b0);
      @(negedge clk);
      v0 = 1'b0;
      repeat (8) @(negedge clk);
      n_cmp++;
      if ({ser0, busy0} !== 2'b01) begin
         n_bad++;
         $display("FAIL mid_pre: got %b want 01", {ser0, busy0});
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ser0, busy0, rdy0, done0} !== 4'b1010) begin
         n_bad++;
         $display("FAIL mid_reset: got %b want 1010",
                  {ser0, busy0, rdy0, done0});
      end
      f = sb.pop_front();
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done0 !== 1'b0 || busy0 !== 1'b0) dn++;
      end
      n_cmp++;
      if (dn !== 0) begin
         n_bad++;
         $display("FAIL mid_nodone: got %0d active cycles want 0", dn);
      end
   endtask

   initial begin
      rst = 1'b1;
      d0 = '0; d1 = '0;
      v0 = 1'b0; v1 = 1'b0;
      o0 = 1'b0; o1 = 1'b0;
      test_reset();
      test_zero_even();
      test_parity();
      test_pattern_81();
      test_back_to_back();
      test_fast();
      test_reset_mid_frame();
      n_cmp++;
      if (sb.size() !== 0) begin
         n_bad++;
         $display("FAIL scoreboard_left: got %0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
